mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 34 +++
 rtl/mem_byte_array.sv | 32 +++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, access
// type codes and the alignment rule that decides when an access is rejected.
package mem_responder_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    DONE    = 2'b10,
    RELEASE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } acc_type_e;

  // Halfwords need an even address, words a 4-byte aligned one; RSVD is never legal.
  function automatic logic access_illegal(input acc_type_e t, input logic [1:0] a_lo);
    logic bad;
    case (t)
      BYTE:    bad = 1'b0;
      HALF:    bad = a_lo[0];
      WORD:    bad = (a_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with four big-endian byte lanes: lane 0 is the addressed
// byte and maps to bits [31:24]; lane 3 is address+3 and maps to bits [7:0].
module mem_byte_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]        mem_q     [DEPTH];
  logic [ADDR_W-1:0] lane_addr [4];

  // we_i[3] enables lane 0 so the enable vector lines up with the data bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_addr[gi]             = addr_i + ADDR_W'(gi);
    assign rdata_o[31-8*gi -: 8]     = mem_q[lane_addr[gi]];
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[3-i]) begin
        mem_q[lane_addr[i]] <= wdata_i[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Four-phase handshake memory responder: captures a request, waits a fixed
// number of cycles, performs the access and holds MOC until MOV is dropped.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 512
) (
  input  logic              Clk,
  input  logic              nClr,
  input  logic              MOV,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [1:0]        Type,
  output logic [DATA_W-1:0] DataOut,
  output logic              MOC,
  output logic              MAE
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  acc_type_e         type_q;
  logic              moc_q;
  logic              mae_q;
  logic [DATA_W-1:0] dout_q;

  logic              access_now;
  logic              illegal;
  logic [3:0]        lane_we;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rd_aligned;

  // The first DONE cycle (MOC still low) is the one in which the access happens.
  always_comb begin
    access_now = (state_q == DONE) && !moc_q;
    illegal    = access_illegal(type_q, addr_q[1:0]);
    lane_we    = 4'b0000;
    lane_wdata = '0;
    rd_aligned = '0;
    case (type_q)
      BYTE: begin
        lane_we    = 4'b1000;
        lane_wdata = {wdata_q[7:0], 24'h0};
        rd_aligned = {24'h0, rdata[31:24]};
      end
      HALF: begin
        lane_we    = 4'b1100;
        lane_wdata = {wdata_q[15:0], 16'h0};
        rd_aligned = {16'h0, rdata[31:16]};
      end
      WORD: begin
        lane_we    = 4'b1111;
        lane_wdata = wdata_q;
        rd_aligned = rdata;
      end
      default: ;
    endcase
    if (!(access_now && !rw_q && !illegal)) begin
      lane_we = 4'b0000;
    end
  end

  mem_byte_array #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i  (Clk),
    .addr_i (addr_q),
    .we_i   (lane_we),
    .wdata_i(lane_wdata),
    .rdata_o(rdata)
  );

  always_ff @(posedge Clk or negedge nClr) begin
    if (!nClr) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= BYTE;
      moc_q   <= 1'b0;
      mae_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MOV) begin
            rw_q    <= RW;
            addr_q  <= Address;
            wdata_q <= DataIn;
            type_q  <= acc_type_e'(Type);
            if (WAIT_STATES == 0) begin
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q <= 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (!moc_q) begin
            moc_q <= 1'b1;
            mae_q <= illegal;
            if (illegal) begin
              dout_q <= '0;
            end else if (rw_q) begin
              dout_q <= rd_aligned;
            end
          end else if (!MOV) begin
            moc_q   <= 1'b0;
            mae_q   <= 1'b0;
            state_q <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DataOut = dout_q;
  assign MOC     = moc_q;
  assign MAE     = mae_q;

endmodule

// File: tb/tb_mem_responder.sv
// Table-driven bench for mem_responder with a scoreboard of expected
// completions plus hand-written handshake and reset sequences.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic        clk;
  logic        n_clr;
  logic        mov;
  logic        rw;
  logic [8:0]  addr;
  logic [31:0] din;
  logic [1:0]  typ;
  logic [31:0] dout;
  logic        moc;
  logic        mae;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] dout;
    logic        mae;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        rw;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [1:0]  typ;
    logic [31:0] exp_dout;
    logic        exp_mae;
  } vec_t;
  localparam int NVEC = 24;
  vec_t vecs[NVEC];

  mem_responder #(
    .WAIT_STATES(2),
    .DEPTH      (512)
  ) dut (
    .Clk    (clk),
    .nClr   (n_clr),
    .MOV    (mov),
    .RW     (rw),
    .Address(addr),
    .DataIn (din),
    .Type   (typ),
    .DataOut(dout),
    .MOC    (moc),
    .MAE    (mae)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete handshake; exp_lat counts edges after the first edge following the drive.
  task automatic do_access(input string name, input logic r, input logic [8:0] a,
                           input logic [31:0] d, input logic [1:0] t,
                           input logic [31:0] e_dout, input logic e_mae,
                           input int hold, input bit early, input bit b2b, input int exp_lat);
    exp_t e;
    int   lat;
    if (!b2b) @(posedge clk);
    @(negedge clk);
    mov  = 1'b1;
    rw   = r;
    addr = a;
    din  = d;
    typ  = t;
    sb_q.push_back('{e_dout, e_mae});
    @(posedge clk);
    #1;
    if (!b2b) begin
      rw   = 1'($urandom);
      addr = 9'($urandom);
      din  = $urandom;
      typ  = 2'($urandom);
      if (early) mov = 1'b0;
    end
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!moc && lat < 16);
    e = sb_q.pop_front();
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (!moc) begin
      mov = 1'b0;
      return;
    end
    check({name, " dout"}, dout, e.dout);
    check({name, " mae"}, 32'(mae), 32'(e.mae));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, " moc_hold"}, 32'(moc), 32'd1);
      check({name, " dout_hold"}, dout, e.dout);
    end
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk);
    #1;
    check({name, " moc_fall"}, 32'(moc), 32'd0);
    check({name, " mae_clear"}, 32'(mae), 32'd0);
    $display("txn %s rw=%0d addr=%h type=%0d dout=%h mae=%0d lat=%0d",
             name, r, a, t, dout, e.mae, lat);
  endtask

  initial begin
    n_clr = 1'b0;
    mov   = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    din   = '0;
    typ   = '0;

    //            rw    addr     data          type  exp_dout      mae
    vecs[0]  = '{1'b0, 9'h010, 32'hDEADBEEF, WORD, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 9'h010, 32'h0,        WORD, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 9'h011, 32'h0,        BYTE, 32'h000000AD, 1'b0};
    vecs[3]  = '{1'b1, 9'h012, 32'h0,        HALF, 32'h0000BEEF, 1'b0};
    vecs[4]  = '{1'b0, 9'h013, 32'hFFFFFF55, BYTE, 32'h0000BEEF, 1'b0};
    vecs[5]  = '{1'b1, 9'h010, 32'h0,        WORD, 32'hDEADBE55, 1'b0};
    vecs[6]  = '{1'b0, 9'h012, 32'h12345678, WORD, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b1, 9'h010, 32'h0,        WORD, 32'hDEADBE55, 1'b0};
    vecs[8]  = '{1'b1, 9'h010, 32'h0,        RSVD, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b0, 9'h040, 32'h01020304, WORD, 32'h00000000, 1'b0};
    vecs[10] = '{1'b0, 9'h042, 32'hAAAA1234, HALF, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 9'h040, 32'h0,        WORD, 32'h01021234, 1'b0};
    vecs[12] = '{1'b1, 9'h040, 32'h0,        HALF, 32'h00000102, 1'b0};
    vecs[13] = '{1'b1, 9'h043, 32'h0,        BYTE, 32'h00000034, 1'b0};
    vecs[14] = '{1'b0, 9'h041, 32'hFFFFFFFF, HALF, 32'h00000000, 1'b1};
    vecs[15] = '{1'b1, 9'h040, 32'h0,        WORD, 32'h01021234, 1'b0};
    vecs[16] = '{1'b0, 9'h1FC, 32'hCAFEF00D, WORD, 32'h01021234, 1'b0};
    vecs[17] = '{1'b1, 9'h1FC, 32'h0,        WORD, 32'hCAFEF00D, 1'b0};
    vecs[18] = '{1'b1, 9'h1FF, 32'h0,        BYTE, 32'h0000000D, 1'b0};
    vecs[19] = '{1'b1, 9'h1FE, 32'h0,        HALF, 32'h0000F00D, 1'b0};
    vecs[20] = '{1'b1, 9'h1FF, 32'h0,        HALF, 32'h00000000, 1'b1};
    vecs[21] = '{1'b1, 9'h011, 32'h0,        WORD, 32'h00000000, 1'b1};
    vecs[22] = '{1'b0, 9'h010, 32'h0,        RSVD, 32'h00000000, 1'b1};
    vecs[23] = '{1'b1, 9'h010, 32'h0,        WORD, 32'hDEADBE55, 1'b0};

    #3;
    check("reset moc", 32'(moc), 32'd0);
    check("reset mae", 32'(mae), 32'd0);
    check("reset dout", dout, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_clr = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].data,
                vecs[i].typ, vecs[i].exp_dout, vecs[i].exp_mae, 0, 1'b0, 1'b0, 3);
    end

    // MOV dropped right after capture: access still completes with a single MOC cycle.
    do_access("early_drop", 1'b1, 9'h010, 32'h0, BYTE, 32'h000000DE, 1'b0, 0, 1'b1, 1'b0, 3);

    // MOV held past MOC, then an immediate follow-on request must wait out RELEASE.
    do_access("hold5", 1'b1, 9'h010, 32'h0, WORD, 32'hDEADBE55, 1'b0, 5, 1'b0, 1'b0, 3);
    do_access("b2b", 1'b1, 9'h012, 32'h0, BYTE, 32'h000000BE, 1'b0, 0, 1'b0, 1'b1, 4);

    // Reset in WAIT must abandon the write and leave storage untouched.
    do_access("pre_rst_wr", 1'b0, 9'h020, 32'hA5A5A5A5, WORD, 32'h000000BE, 1'b0, 0, 1'b0, 1'b0, 3);
    @(posedge clk);
    @(negedge clk);
    mov  = 1'b1;
    rw   = 1'b0;
    addr = 9'h020;
    din  = 32'h11223344;
    typ  = WORD;
    @(posedge clk);
    @(posedge clk);
    #2;
    n_clr = 1'b0;
    #1;
    check("midrst moc", 32'(moc), 32'd0);
    check("midrst mae", 32'(mae), 32'd0);
    check("midrst dout", dout, 32'h0);
    check("midrst state", 32'(dut.state_q), 32'(IDLE));
    check("midrst cnt", 32'(dut.cnt_q), 32'd0);
    @(negedge clk);
    mov   = 1'b0;
    n_clr = 1'b1;
    $display("txn midrst write addr=020 abandoned");
    do_access("rst_readback", 1'b1, 9'h020, 32'h0, WORD, 32'hA5A5A5A5, 1'b0, 0, 1'b0, 1'b0, 3);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
